// File: rtl/mips_alu_pkg.sv
// Shared definitions for the R-type ALU issue controller:
// ALU_OP codes, funct codes and FSM states.
package mips_alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_XNOR = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_SLLV = 3'b111;

  localparam logic [5:0] OPC_RTYPE = 6'h00;

  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_XNOR = 6'h27;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLLV = 6'h04;

  // Bit positions inside the {ZF,CF,OF} flag vector
  localparam int FLAG_ZF = 2;
  localparam int FLAG_CF = 1;
  localparam int FLAG_OF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

endpackage

// File: rtl/mips_funct_dec.sv
// Combinational opcode/funct decoder producing ALU_OP,
// a legality flag and an ADD/SUB indicator.
module mips_funct_dec
  import mips_alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       legal,
  output logic       is_arith
);

  // Undecodable words fall back to OP_AND with legal low
  always_comb begin
    alu_op   = OP_AND;
    legal    = 1'b0;
    is_arith = 1'b0;
    if (opcode == OPC_RTYPE) begin
      unique case (funct)
        FN_AND: begin
          alu_op = OP_AND;
          legal  = 1'b1;
        end
        FN_OR: begin
          alu_op = OP_OR;
          legal  = 1'b1;
        end
        FN_XOR: begin
          alu_op = OP_XOR;
          legal  = 1'b1;
        end
        FN_XNOR: begin
          alu_op = OP_XNOR;
          legal  = 1'b1;
        end
        FN_ADD: begin
          alu_op   = OP_ADD;
          legal    = 1'b1;
          is_arith = 1'b1;
        end
        FN_SUB: begin
          alu_op   = OP_SUB;
          legal    = 1'b1;
          is_arith = 1'b1;
        end
        FN_SLT: begin
          alu_op = OP_SLT;
          legal  = 1'b1;
        end
        FN_SLLV: begin
          alu_op = OP_SLLV;
          legal  = 1'b1;
        end
        default: begin
          alu_op = OP_AND;
          legal  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mips_alu_ctrl.sv
// Four-state R-type issue controller: accept, read rs/rt,
// drive the ALU, write the result back to rd.
module mips_alu_ctrl
  import mips_alu_pkg::*;
#(
  parameter int W  = 32,
  parameter int RA = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inst_valid,
  output logic          inst_ready,
  input  logic [31:0]   inst,
  output logic [RA-1:0] rf_ra_addr,
  output logic [RA-1:0] rf_rb_addr,
  input  logic [W-1:0]  rf_ra_data,
  input  logic [W-1:0]  rf_rb_data,
  output logic [2:0]    alu_op,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  input  logic [W-1:0]  alu_f,
  input  logic          alu_zf,
  input  logic          alu_cf,
  input  logic          alu_of,
  output logic          rf_we,
  output logic [RA-1:0] rf_w_addr,
  output logic [W-1:0]  rf_w_data,
  output logic [2:0]    flags,
  output logic          done,
  output logic          illegal
);

  state_t          state;
  logic [5:0]      opcode_q;
  logic [5:0]      funct_q;
  logic [RA-1:0]   rd_q;
  logic [2:0]      dec_op;
  logic            dec_legal;
  logic            dec_arith;

  // shamt is not used by any supported instruction
  logic            unused_shamt;
  assign unused_shamt = ^inst[10:6];

  mips_funct_dec u_dec (
    .opcode   (opcode_q),
    .funct    (funct_q),
    .alu_op   (dec_op),
    .legal    (dec_legal),
    .is_arith (dec_arith)
  );

  // Issue FSM with registered handshake, ALU and write-back outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      inst_ready <= 1'b1;
      opcode_q   <= '0;
      funct_q    <= '0;
      rd_q       <= '0;
      rf_ra_addr <= '0;
      rf_rb_addr <= '0;
      alu_op     <= OP_AND;
      alu_a      <= '0;
      alu_b      <= '0;
      rf_we      <= 1'b0;
      rf_w_addr  <= '0;
      rf_w_data  <= '0;
      flags      <= 3'b000;
      done       <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      rf_we   <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      unique case (state)
        IDLE: begin
          if (inst_valid) begin
            opcode_q   <= inst[31:26];
            funct_q    <= inst[5:0];
            rd_q       <= RA'(inst[15:11]);
            rf_ra_addr <= RA'(inst[25:21]);
            rf_rb_addr <= RA'(inst[20:16]);
            inst_ready <= 1'b0;
            state      <= READ;
          end
        end
        READ: begin
          alu_op <= dec_op;
          state  <= EXEC;
        end
        EXEC: begin
          alu_a <= rf_ra_data;
          alu_b <= rf_rb_data;
          state <= WB;
        end
        WB: begin
          done       <= 1'b1;
          illegal    <= ~dec_legal;
          rf_w_addr  <= rd_q;
          rf_w_data  <= alu_f;
          rf_we      <= dec_legal && (rd_q != '0);
          if (dec_legal) begin
            flags[FLAG_ZF] <= alu_zf;
            if (dec_arith) begin
              flags[FLAG_CF] <= alu_cf;
              flags[FLAG_OF] <= alu_of;
            end
          end
          inst_ready <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_ctrl.sv
// Bench for mips_alu_ctrl: register-file and ALU stubs,
// an instruction-level reference model and directed vectors.
module tb_mips_alu_ctrl;

  localparam int W  = 32;
  localparam int RA = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst;
  logic [RA-1:0] rf_ra_addr;
  logic [RA-1:0] rf_rb_addr;
  logic [W-1:0]  rf_ra_data;
  logic [W-1:0]  rf_rb_data;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_a;
  logic [W-1:0]  alu_b;
  logic [W-1:0]  alu_f;
  logic          alu_zf;
  logic          alu_cf;
  logic          alu_of;
  logic          rf_we;
  logic [RA-1:0] rf_w_addr;
  logic [W-1:0]  rf_w_data;
  logic [2:0]    flags;
  logic          done;
  logic          illegal;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mips_alu_ctrl #(.W(W), .RA(RA)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .rf_ra_data (rf_ra_data),
    .rf_rb_data (rf_rb_data),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_f      (alu_f),
    .alu_zf     (alu_zf),
    .alu_cf     (alu_cf),
    .alu_of     (alu_of),
    .rf_we      (rf_we),
    .rf_w_addr  (rf_w_addr),
    .rf_w_data  (rf_w_data),
    .flags      (flags),
    .done       (done),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Static register file with one-cycle read latency
  logic [31:0] rf [32];
  always @(posedge clk) begin
    rf_ra_data <= rf[rf_ra_addr];
    rf_rb_data <= rf[rf_rb_addr];
  end

  // ALU stub; logic ops drive junk CF/OF so holding is visible
  logic [32:0] alu_s;
  always_comb begin
    alu_s  = '0;
    alu_f  = '0;
    alu_cf = 1'b1;
    alu_of = 1'b1;
    case (alu_op)
      3'd0: alu_f = alu_a & alu_b;
      3'd1: alu_f = alu_a | alu_b;
      3'd2: alu_f = alu_a ^ alu_b;
      3'd3: alu_f = ~(alu_a ^ alu_b);
      3'd4: begin
        alu_s  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_f  = alu_s[31:0];
        alu_cf = alu_s[32];
        alu_of = (alu_a[31] == alu_b[31]) && (alu_f[31] != alu_a[31]);
      end
      3'd5: begin
        alu_f  = alu_a - alu_b;
        alu_cf = alu_a < alu_b;
        alu_of = (alu_a[31] != alu_b[31]) && (alu_f[31] != alu_a[31]);
      end
      3'd6: alu_f = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_f = alu_b << alu_a[4:0];
    endcase
    alu_zf = (alu_f == '0);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt,
                                        input int rd, input logic [5:0] fn);
    logic [4:0] s;
    logic [4:0] t;
    logic [4:0] d;
    s = 5'(rs);
    t = 5'(rt);
    d = 5'(rd);
    return {6'd0, s, t, d, 5'd0, fn};
  endfunction

  typedef struct {
    int          due;
    bit          ill;
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [2:0]  fl;
  } exp_t;

  exp_t       q[$];
  logic [2:0] mflags;
  logic [2:0] cur_flags;

  // Instruction-level semantics of one R-type word
  function automatic exp_t predict(input logic [31:0] ins, input int due,
                                   input logic [2:0] prev);
    exp_t        e;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [32:0] s;
    bit          legal;
    bit          arith;
    bit          c;
    bit          o;
    a = rf[ins[25:21]];
    b = rf[ins[20:16]];
    r = '0;
    c = 0;
    o = 0;
    legal = 1;
    arith = 0;
    if (ins[31:26] != 6'd0) legal = 0;
    else begin
      case (ins[5:0])
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a ^ b);
        6'h20: begin
          s = {1'b0, a} + {1'b0, b};
          r = s[31:0];
          c = s[32];
          o = (a[31] == b[31]) && (r[31] != a[31]);
          arith = 1;
        end
        6'h22: begin
          r = a - b;
          c = a < b;
          o = (a[31] != b[31]) && (r[31] != a[31]);
          arith = 1;
        end
        6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h04: r = b << a[4:0];
        default: legal = 0;
      endcase
    end
    e.due  = due;
    e.addr = ins[15:11];
    e.data = r;
    e.fl   = prev;
    e.ill  = !legal;
    e.we   = legal && (ins[15:11] != 5'd0);
    if (legal) begin
      e.fl[2] = (r == 0);
      if (arith) e.fl[1:0] = {c, o};
    end
    return e;
  endfunction

  // Model: record each accepted instruction with its due cycle
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      q.delete();
      mflags    = 3'b000;
      cur_flags = 3'b000;
    end else if (inst_valid && inst_ready) begin
      e = predict(inst, cyc + 3, mflags);
      mflags = e.fl;
      q.push_back(e);
    end
  end

  // Compare DUT outputs against the model every cycle
  always @(negedge clk) begin
    exp_t e;
    bit   exp_done;
    bit   exp_ready;
    if (cyc > 0) begin
      exp_done  = (q.size() > 0) && (q[0].due == cyc);
      exp_ready = (q.size() == 0) || exp_done;
      chk("m_done", done, exp_done);
      chk("m_ready", inst_ready, exp_ready);
      if (exp_done) begin
        e = q.pop_front();
        cur_flags = e.fl;
        chk("m_illegal", illegal, e.ill);
        chk("m_we", rf_we, e.we);
        if (e.we) begin
          chk("m_waddr", rf_w_addr, e.addr);
          chk("m_wdata", rf_w_data, e.data);
        end
      end else begin
        chk("m_illegal_idle", illegal, 0);
        chk("m_we_idle", rf_we, 0);
      end
      chk("m_flags", flags, cur_flags);
      if (q.size() > 0 && q[0].due < cyc) begin
        chk("m_stale", 1, 0);
        void'(q.pop_front());
      end
    end
  end

  // Issue one word and stop #1 into the done cycle
  task automatic run(input logic [31:0] ins, output logic [2:0] wb_op);
    int n = 0;
    @(negedge clk);
    inst = ins;
    inst_valid = 1'b1;
    while (!inst_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) chk("hs_timeout", 1, 0);
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    inst = 32'hFFFF_FFFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    wb_op = alu_op;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] op_seen;
  int         h0;
  int         h1;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1111_1111 * i;
    rf[0]  = 32'h0000_0000;
    rf[1]  = 32'h7FFF_FFFF;
    rf[2]  = 32'h0000_0001;
    rf[6]  = 32'h1234_5678;
    rf[7]  = 32'hF0F0_F0F0;
    rf[8]  = 32'h0F0F_0F0F;
    rf[9]  = 32'h0000_0004;
    rf[10] = 32'h0000_0003;
    rf[11] = 32'h0000_0024;
    rf[12] = 32'hFFFF_FFFE;
    rf[13] = 32'h0000_0005;
    rst_n = 1'b0;
    inst_valid = 1'b0;
    inst = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", inst_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 0);
    chk("rst_aluop", alu_op, 0);
    chk("rst_we", rf_we, 0);
    rst_n = 1'b1;

    run(rtype(1, 2, 3, 6'h20), op_seen);
    chk("add_done", done, 1);
    chk("add_we", rf_we, 1);
    chk("add_waddr", rf_w_addr, 3);
    chk("add_wdata", rf_w_data, 32'h8000_0000);
    chk("add_flags", flags, 3'b001);

    run(32'h0800_0000, op_seen);
    chk("ill_done", done, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_we", rf_we, 0);
    chk("ill_flags", flags, 3'b001);
    chk("ill_op", op_seen, 0);
    @(posedge clk);
    #1;
    chk("ill_ready_next", inst_ready, 1);

    run(rtype(6, 6, 4, 6'h22), op_seen);
    chk("sub_wdata", rf_w_data, 0);
    chk("sub_flags", flags, 3'b100);

    run(rtype(7, 8, 7, 6'h24), op_seen);
    chk("and_flags", flags, 3'b100);

    run(rtype(9, 10, 5, 6'h04), op_seen);
    chk("sllv_wdata", rf_w_data, 32'h0000_0030);
    chk("sllv_op", op_seen, 3'b111);

    run(rtype(11, 10, 6, 6'h04), op_seen);
    chk("sllv_mask", rf_w_data, 32'h0000_0030);

    run(rtype(12, 13, 8, 6'h25), op_seen);
    run(rtype(12, 13, 9, 6'h26), op_seen);
    run(rtype(12, 13, 10, 6'h27), op_seen);
    chk("xnor_wdata", rf_w_data, 32'h0000_0004);
    run(rtype(12, 13, 11, 6'h2A), op_seen);
    chk("slt_wdata", rf_w_data, 1);
    run(rtype(13, 12, 11, 6'h2A), op_seen);

    run(rtype(2, 1, 9, 6'h22), op_seen);
    chk("sub_borrow", rf_w_data, 32'h8000_0002);
    chk("sub_bflags", flags, 3'b010);
    run(rtype(1, 2, 9, 6'h3F), op_seen);
    chk("badfn_ill", illegal, 1);
    chk("badfn_flags", flags, 3'b010);

    run(rtype(1, 2, 0, 6'h20), op_seen);
    chk("rd0_we", rf_we, 0);
    chk("rd0_done", done, 1);
    chk("rd0_flags", flags, 3'b001);

    @(negedge clk);
    inst = rtype(1, 2, 14, 6'h20);
    inst_valid = 1'b1;
    @(posedge clk);
    #1;
    h0 = cyc;
    inst = rtype(6, 6, 15, 6'h22);
    begin
      int n = 0;
      while (!inst_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (n >= 10) chk("b2b_timeout", 1, 0);
    end
    @(posedge clk);
    #1;
    h1 = cyc;
    inst_valid = 1'b0;
    chk("b2b_gap", h1 - h0, 4);
    repeat (4) @(negedge clk);

    @(negedge clk);
    inst = rtype(7, 8, 12, 6'h25);
    inst_valid = 1'b1;
    @(posedge clk);
    #1;
    inst_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ready", inst_ready, 1);
    chk("abort_done", done, 0);
    chk("abort_we", rf_we, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    run(rtype(6, 13, 16, 6'h20), op_seen);
    chk("recover_wdata", rf_w_data, 32'h1234_567D);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
